// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC/nPC pair with delayed-branch semantics,
// drives the instruction memory address and registers the fetched word into IF/ID.
module if_fetch_stage #(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              le,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       pc_out,
    output logic [31:0]       npc_out,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        badTarget;

    assign badTarget = branch_taken && (branch_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        err_d   = err_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // A stall holds everything, including any branch request; ID reasserts it.
                if (le) begin
                    instr_d = imem_data;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = npc_q;
                    if (badTarget) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else if (branch_taken) begin
                        npc_d = branch_target;
                    end else begin
                        npc_d = npc_q + 32'd4;
                    end
                end
            end
            HALT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
            instr_q <= NOP_WORD;
            ifpc_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr    = pc_q[ADDR_W-1:0];
    assign pc_out       = pc_q;
    assign npc_out      = npc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the fetch stage.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        le;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        misalign_err;

    logic [31:0] mem [128];

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model of the architectural state
    logic [31:0] mPc, mNpc, mInstr, mIfPc;
    logic        mValid, mErr, mBoot, mHalt;

    if_fetch_stage #(.ADDR_W(9), .RESET_PC(32'd0), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .le           (le),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc_out       (pc_out),
        .npc_out      (npc_out),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[8:2]];

    // Advance the model by one edge using the inputs currently applied
    task automatic modelStep();
        logic [31:0] word;
        word = mem[mPc[8:2]];
        if (!reset) begin
            mPc = 32'd0; mNpc = 32'd4; mInstr = NOP; mIfPc = 32'd0;
            mValid = 1'b0; mErr = 1'b0; mBoot = 1'b1; mHalt = 1'b0;
        end else if (mBoot) begin
            mBoot = 1'b0;
        end else if (mHalt) begin
            mInstr = NOP; mValid = 1'b0;
        end else if (le) begin
            mInstr = word; mIfPc = mPc; mValid = 1'b1;
            if (branch_taken && branch_target[1:0] != 2'b00) begin
                mPc = mNpc; mErr = 1'b1; mHalt = 1'b1;
            end else begin
                mPc  = mNpc;
                mNpc = branch_taken ? branch_target : mNpc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic b, input logic [31:0] t);
        reset = r; le = l; branch_taken = b; branch_target = t;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        tick();
        tick();
        testsRun++;
        if (pc_out !== 32'd0 || npc_out !== 32'd4) begin
            testsFailed++;
            $display("[TB] FAIL reset_pc: got pc=%h npc=%h expected pc=0 npc=4", pc_out, npc_out);
        end
        testsRun++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd0 || misalign_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ifid: got v=%b i=%h p=%h e=%b expected 0/0/0/0",
                     if_id_valid, if_id_instr, if_id_pc, misalign_err);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expInstr [3];
        expInstr[0] = 32'h1111_1111; expInstr[1] = 32'h2222_2222; expInstr[2] = 32'h3333_3333;
        doReset();
        tick();
        testsRun++;
        if (if_id_valid !== 1'b0 || pc_out !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL boot_edge: got v=%b pc=%h expected v=0 pc=0", if_id_valid, pc_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (if_id_instr !== expInstr[i] || if_id_pc !== 32'(i * 4) || if_id_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL seq_capture%0d: got i=%h p=%h v=%b expected i=%h p=%h v=1",
                         i, if_id_instr, if_id_pc, if_id_valid, expInstr[i], 32'(i * 4));
            end
        end
        testsRun++;
        if (pc_out !== 32'd12 || npc_out !== 32'd16) begin
            testsFailed++;
            $display("[TB] FAIL seq_pc: got pc=%h npc=%h expected pc=c npc=10", pc_out, npc_out);
        end
    endtask

    task automatic test_stall();
        doReset();
        tick(); tick(); tick();
        le = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (pc_out !== 32'd8 || npc_out !== 32'd12 || if_id_pc !== 32'd4 || if_id_instr !== 32'h2222_2222) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold%0d: got pc=%h npc=%h p=%h i=%h expected 8/c/4/22222222",
                         i, pc_out, npc_out, if_id_pc, if_id_instr);
            end
        end
        le = 1'b1;
        tick();
        testsRun++;
        if (if_id_instr !== 32'h3333_3333 || if_id_pc !== 32'd8) begin
            testsFailed++;
            $display("[TB] FAIL stall_resume: got i=%h p=%h expected 33333333/8", if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] expPc [4];
        expPc[0] = 32'd4; expPc[1] = 32'd8; expPc[2] = 32'h40; expPc[3] = 32'h44;
        doReset();
        tick(); tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 4; i++) begin
            tick();
            branch_taken = 1'b0;
            testsRun++;
            if (if_id_pc !== expPc[i]) begin
                testsFailed++;
                $display("[TB] FAIL branch_seq%0d: got p=%h expected %h", i, if_id_pc, expPc[i]);
            end
        end
    endtask

    task automatic test_stalled_branch();
        logic [31:0] npcBefore;
        npcBefore = npc_out;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
        tick();
        testsRun++;
        if (npc_out !== npcBefore) begin
            testsFailed++;
            $display("[TB] FAIL stalled_branch_hold: got npc=%h expected %h", npc_out, npcBefore);
        end
        le = 1'b1;
        tick();
        branch_taken = 1'b0;
        testsRun++;
        if (npc_out !== 32'h80) begin
            testsFailed++;
            $display("[TB] FAIL stalled_branch_take: got npc=%h expected 80", npc_out);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] pcHeld, npcHeld;
        npcHeld = npc_out;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
        tick();
        branch_taken = 1'b0;
        testsRun++;
        if (misalign_err !== 1'b1 || if_id_valid !== 1'b1 || npc_out !== npcHeld || pc_out !== npcHeld) begin
            testsFailed++;
            $display("[TB] FAIL misalign_edge: got e=%b v=%b pc=%h npc=%h expected 1/1/%h/%h",
                     misalign_err, if_id_valid, pc_out, npc_out, npcHeld, npcHeld);
        end
        pcHeld = pc_out;
        for (int i = 0; i < 4; i++) begin
            le = i[0];
            tick();
            testsRun++;
            if (if_id_valid !== 1'b0 || if_id_instr !== NOP || pc_out !== pcHeld ||
                npc_out !== npcHeld || misalign_err !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL halt%0d: got v=%b i=%h pc=%h npc=%h e=%b expected 0/0/%h/%h/1",
                         i, if_id_valid, if_id_instr, pc_out, npc_out, misalign_err, pcHeld, npcHeld);
            end
        end
    endtask

    task automatic test_reset_priority();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h42);
        tick();
        testsRun++;
        if (pc_out !== 32'd0 || npc_out !== 32'd4 || misalign_err !== 1'b0 || if_id_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_priority: got pc=%h npc=%h e=%b v=%b expected 0/4/0/0",
                     pc_out, npc_out, misalign_err, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        doReset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1FC);
        tick();
        branch_taken = 1'b0;
        tick();
        testsRun++;
        if (pc_out !== 32'h1FC || imem_addr !== 9'h1FC || npc_out !== 32'h200) begin
            testsFailed++;
            $display("[TB] FAIL wrap_pre: got pc=%h a=%h npc=%h expected 1fc/1fc/200", pc_out, imem_addr, npc_out);
        end
        tick();
        testsRun++;
        if (imem_addr !== 9'h000 || pc_out !== 32'h200) begin
            testsFailed++;
            $display("[TB] FAIL wrap_addr: got a=%h pc=%h expected 000/200", imem_addr, pc_out);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        branch_taken = 1'b0;
        tick();
        testsRun++;
        if (pc_out !== 32'hFFFF_FFFC || npc_out !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_npc: got pc=%h npc=%h expected fffffffc/0", pc_out, npc_out);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        doReset();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) >= 2);
            le           = ($urandom_range(0, 99) < 70);
            branch_taken = ($urandom_range(0, 99) < 20);
            branch_target = {23'd0, 9'($urandom_range(0, 511))} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 4) branch_target[1:0] = 2'($urandom_range(1, 3));
            tick();
            testsRun++;
            if (pc_out !== mPc || npc_out !== mNpc || if_id_instr !== mInstr || if_id_pc !== mIfPc ||
                if_id_valid !== mValid || misalign_err !== mErr || imem_addr !== mPc[8:0]) begin
                testsFailed++;
                errs++;
                if (errs <= 5)
                    $display("[TB] FAIL random%0d: got pc=%h npc=%h i=%h p=%h v=%b e=%b expected pc=%h npc=%h i=%h p=%h v=%b e=%b",
                             i, pc_out, npc_out, if_id_instr, if_id_pc, if_id_valid, misalign_err,
                             mPc, mNpc, mInstr, mIfPc, mValid, mErr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
        mPc = 0; mNpc = 4; mInstr = NOP; mIfPc = 0;
        mValid = 0; mErr = 0; mBoot = 1; mHalt = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_stalled_branch();
        test_misalign();
        test_reset_priority();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register and control unit.
- Owns the PC/nPC pair with delayed-branch semantics: the instruction after a branch (delay slot) always executes.
- Drives the combinational instruction memory address and captures the returned word, with its PC, into an internal IF/ID register.
- Supports a load-enable stall from hazard logic and halts on a misaligned branch target.

Parameters:
- ADDR_W, 9, width of the instruction memory byte address driven on imem_addr.
- RESET_PC, 32'd0, PC value loaded on reset; nPC loads RESET_PC+4.
- NOP_WORD, 32'h00000000, instruction word placed in IF/ID when the stage holds no valid instruction.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- le  in  1  load enable from hazard unit; 1 = advance, 0 = stall (hold all state).
- branch_taken  in  1  from ID; redirect nPC to branch_target.
- branch_target  in  32  byte address of the taken branch or jump.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc_out[ADDR_W-1:0] (combinational).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- pc_out  out  32  current PC.
- npc_out  out  32  current nPC.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real fetched instruction.
- misalign_err  out  1  sticky; target[1:0] != 0 was accepted.

Behaviour:
- Reset (reset==0 at posedge; dominates all other inputs):
  - pc_out=RESET_PC, npc_out=RESET_PC+4.
  - if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, misalign_err=0.
  - State=BOOT.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - The first posedge with reset==1 goes to RUN.
  - No capture and no PC/nPC change in BOOT; if_id_valid stays 0.
  - le and branch_taken are ignored in BOOT.
- RUN, le==1, at posedge:
  - if_id_instr<=imem_data, if_id_pc<=pc_out, if_id_valid<=1.
  - pc_out<=npc_out.
  - npc_out<=branch_taken ? branch_target : npc_out+4.
- RUN, le==0: PC, nPC and the IF/ID outputs all hold. branch_taken is ignored; ID holds the branch and reasserts it.
- Delay slot: a branch seen in ID while the delay-slot instruction is at PC gives a fetch order of branch, slot, target. Nothing is flushed.
- Misaligned target:
  - Trigger: RUN, le==1, branch_taken==1, branch_target[1:0]!=0.
  - That edge performs the normal capture and pc_out<=npc_out, but nPC holds.
  - misalign_err<=1 and the FSM goes to HALT.
- HALT:
  - PC and nPC frozen.
  - At each posedge: if_id_instr<=NOP_WORD, if_id_valid<=0.
  - Only reset leaves HALT.
- Arithmetic:
  - npc_out+4 wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
  - imem_addr truncates pc_out to ADDR_W bits, so the fetch address wraps at 2^ADDR_W.
- Latency:
  - The instruction at PC appears on if_id_instr one cycle after the fetch edge.
  - The first valid instruction (RESET_PC) appears after the second posedge following reset release: BOOT edge, then capture edge.
- Reset mid-operation (any state, including HALT or stall): the block returns to the reset values at that edge; in-flight IF/ID contents are discarded.

Test Plan:
- Sequential fetch: reset low 1 cycle; memory words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8; le=1 → if_id_valid=0 after the BOOT edge, then if_id_instr/if_id_pc = 0x11111111/0, 0x22222222/4, 0x33333333/8 on successive edges; pc_out=12, npc_out=16 after the third capture.
- Stall: le=0 for 3 cycles while pc_out=8 → pc_out=8, npc_out=12, and if_id_instr/if_id_pc unchanged throughout; on le=1 the fetch resumes with the word at 8.
- Delayed branch: at pc_out=4 (branch at 0 now in ID), branch_taken=1, branch_target=0x40 for one cycle → if_id_pc sequence 4, 8, 0x40, 0x44.
- Stalled branch: branch_taken=1 with le=0 → npc_out unchanged; reassert with le=1 → npc_out=target.
- Misaligned target: branch_target=0x42 accepted → misalign_err=1; next edges if_id_valid=0 and if_id_instr=NOP_WORD; pc_out and npc_out frozen; le toggling has no effect.
- Reset priority and wrap:
  - reset=0 together with branch_taken=1 → reset values; misalign_err cleared.
  - Separately, force PC to 0x1FC with ADDR_W=9 → next imem_addr=0x000, and npc_out carries 0x200 on the full 32 bits.
